fifo_uart_tx: RTL
=================

# fifo_uart_tx

Downstream drain stage for the 8-bit `fifo` buffer. It pulls one byte at a time from the FIFO whenever it is non-empty and serialises it as an 8N1 UART frame (start, 8 data LSB-first, stop) on `tx`. It connects directly to the FIFO's `data_out`, `en_read` and `underflow` (empty indicator) pins and runs on the same clock.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit; legal range 2..65535.
- `DATA_W`, default 8: byte width; must match the FIFO width.

Ports:
- `clk`  input  1  system clock, rising-edge.
- `reset`  input  1  asynchronous, active-low reset.
- `fifo_empty`  input  1  FIFO empty flag, tied to FIFO `underflow`.
- `fifo_data`  input  DATA_W  FIFO `data_out`; valid the cycle after `fifo_rd_en`.
- `fifo_rd_en`  output  1  registered one-cycle read strobe, tied to FIFO `en_read`.
- `tx`  output  1  serial line, idle high.
- `busy`  output  1  high from FETCH through end of STOP.
- `tx_done`  output  1  one-cycle pulse on the last cycle of STOP.

## Operation

- States: IDLE, FETCH, LATCH, START, DATA, (PARITY), STOP.
- IDLE: `tx`=1. `fifo_empty` is sampled only here. If it is 0, go to FETCH next cycle.
- FETCH (1 cycle): `fifo_rd_en`=1. Go to LATCH.
- LATCH (1 cycle): `fifo_data` is captured into the shift register and the bit index is cleared. Go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles.
- DATA: `tx`=shreg[0] for CLKS_PER_BIT cycles per bit, then shift right. After bit DATA_W-1, go to PARITY if enabled, else STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles. `tx_done` is high on the final cycle. Then go to IDLE.
- The bit counter counts 0..CLKS_PER_BIT-1 and is cleared on every state entry. It is sized $clog2(CLKS_PER_BIT).
- Back-to-back: IDLE lasts one cycle when the FIFO is non-empty, so the start-to-start period is (DATA_W+2)*CLKS_PER_BIT + 3 cycles (+CLKS_PER_BIT with parity).
- `fifo_empty` changes outside IDLE are ignored. Exactly one read is issued per frame, so the block never reads an empty FIFO (no underflow caused).
- Reset asserted mid-frame: immediately `tx`=1, `fifo_rd_en`=0, `busy`=0, `tx_done`=0, state IDLE. The in-flight byte is discarded.

## Timing

- Reset values: `tx`=1, `fifo_rd_en`=0, `busy`=0, `tx_done`=0, state IDLE, counters 0.
- All outputs are registered; there are no combinational input-to-output paths.
- Cycle N: IDLE samples `fifo_empty`=0. N+1: `fifo_rd_en`=1, `busy`=1. N+2: byte captured. N+3: `tx` falls (start bit).
- `tx_done` is high in cycle N+3+(DATA_W+2)*CLKS_PER_BIT-1. `busy` falls the following cycle.

## Configuration

- `FIFO_UART_TX_PARITY_EN` defined: insert a PARITY state after DATA. It drives even parity (XOR of the captured byte) for CLKS_PER_BIT cycles; the frame becomes 8E1.
- Undefined: no PARITY state; the frame is 8N1.

## Structure

- Package `fifo_uart_pkg`: the state enum `uart_tx_state_t` and the constants `UART_IDLE_LVL`=1, `UART_START_LVL`=0, `UART_STOP_LVL`=1.
- One sub-module `uart_baud_cnt`: a bit-period counter with `clear` and `tick` (asserted on count CLKS_PER_BIT-1).

## Test plan

- Reset with `fifo_empty`=1 held for 100 cycles -> `tx`=1, `busy`=0, `fifo_rd_en` never asserted.
- One byte 8'hA5, CLKS_PER_BIT=4 -> `fifo_rd_en` pulses once. `tx` sequence per bit: 0,1,0,1,0,0,1,0,1,1. `tx_done` pulses at start+39 cycles.
- Three bytes 8'h00, 8'hFF, 8'h3C queued -> three frames in order, start-to-start 43 cycles, exactly three read strobes.
- Reset pulled low during bit 3 of 8'h55 -> `tx`=1 the same cycle. After release, the next queued byte is sent with a full frame.
- With `FIFO_UART_TX_PARITY_EN`, send 8'h07 -> parity bit=1; send 8'h03 -> parity bit=0. The frame is 11 bits.
- `fifo_empty` toggles during DATA -> no extra `fifo_rd_en`; the current frame is unaffected.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// -----------------------------------------------------------------------------
// fifo_uart_pkg
// Shared types and line levels for the FIFO-draining UART transmitter.
//   uart_tx_state_t : transmitter FSM states
//   UART_*_LVL      : serial line levels for idle, start and stop bits
// -----------------------------------------------------------------------------
package fifo_uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LATCH,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_tx_state_t;

   localparam logic UART_IDLE_LVL  = 1'b1;
   localparam logic UART_START_LVL = 1'b0;
   localparam logic UART_STOP_LVL  = 1'b1;

endpackage : fifo_uart_pkg

// File: rtl/uart_baud_cnt.sv
// -----------------------------------------------------------------------------
// uart_baud_cnt
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps.
//   clk      : system clock
//   reset    : asynchronous, active-low reset
//   clear    : synchronous clear, forces the count to 0 next cycle
//   tick     : count is CLKS_PER_BIT-1 (last cycle of a bit period)
//   pre_tick : count is CLKS_PER_BIT-2 (next cycle is the last one)
// -----------------------------------------------------------------------------
module uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick,
   output logic pre_tick
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick     = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
   assign pre_tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 2));

   always_comb begin
      if (clear || tick) cnt_d = '0;
      else               cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule : uart_baud_cnt

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Drains an 8-bit FIFO one byte at a time and serialises each byte as a UART
// frame (start, DATA_W data bits LSB-first, optional even parity, stop).
// Optional feature macro: FIFO_UART_TX_PARITY_EN (adds an even-parity bit).
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-low reset
//   fifo_empty : FIFO empty flag, sampled only while idle
//   fifo_data  : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en : one-cycle read strobe, one per frame
//   tx         : serial line, idle high
//   busy       : high from the fetch cycle through the end of the stop bit
//   tx_done    : one-cycle pulse on the last cycle of the stop bit
// -----------------------------------------------------------------------------
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_W       = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_rd_en,
   output logic              tx,
   output logic              busy,
   output logic              tx_done
);

   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   uart_tx_state_t    state_q,   state_d;
   logic [DATA_W-1:0] shreg_q,   shreg_d;
   logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
   logic              tx_q,      tx_d;
   logic              rd_en_q,   rd_en_d;
   logic              busy_q,    busy_d;
   logic              done_q,    done_d;
`ifdef FIFO_UART_TX_PARITY_EN
   logic              par_q,     par_d;
`endif

   logic baud_clear;
   logic baud_tick;
   logic baud_pre_tick;

   // The bit-period counter restarts on every state entry and is held at zero
   // in the untimed states, so each timed state starts with a full period.
   assign baud_clear = (state_d != state_q) ||
                       (state_q inside {ST_IDLE, ST_FETCH, ST_LATCH});

   uart_baud_cnt #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_cnt (
      .clk      (clk),
      .reset    (reset),
      .clear    (baud_clear),
      .tick     (baud_tick),
      .pre_tick (baud_pre_tick)
   );

   // NOTE: every signal assigned here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_idx_d = bit_idx_q;
`ifdef FIFO_UART_TX_PARITY_EN
      par_d     = par_q;
`endif
      unique case (state_q)
         ST_IDLE:  if (!fifo_empty) state_d = ST_FETCH;
         ST_FETCH: state_d = ST_LATCH;
         ST_LATCH: begin
            shreg_d   = fifo_data;
            bit_idx_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            par_d     = ^fifo_data;
`endif
            state_d   = ST_START;
         end
         ST_START: if (baud_tick) state_d = ST_DATA;
         ST_DATA: begin
            if (baud_tick) begin
               shreg_d = shreg_q >> 1;
               if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
`ifdef FIFO_UART_TX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + IDX_W'(1);
               end
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         ST_PARITY: if (baud_tick) state_d = ST_STOP;
`endif
         ST_STOP:  if (baud_tick) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Outputs are registered from the next state so they change together
      // with the state they describe, with no input-to-output paths.
      case (state_d)
         ST_START:  tx_d = UART_START_LVL;
         ST_DATA:   tx_d = shreg_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
         ST_PARITY: tx_d = par_d;
`endif
         ST_STOP:   tx_d = UART_STOP_LVL;
         default:   tx_d = UART_IDLE_LVL;
      endcase
      rd_en_d = (state_d == ST_FETCH);
      busy_d  = (state_d != ST_IDLE);
      // pre_tick in STOP means the following cycle is the final stop cycle.
      done_d  = (state_q == ST_STOP) && baud_pre_tick;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values from before the clock edge, regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         bit_idx_q <= '0;
         tx_q      <= UART_IDLE_LVL;
         rd_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_idx_q <= bit_idx_d;
         tx_q      <= tx_d;
         rd_en_q   <= rd_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   assign fifo_rd_en = rd_en_q;
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign tx_done    = done_q;

endmodule : fifo_uart_tx
